// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared types and constants for the CAN bit receiver
// Purpose: receiver state enum, bus level constants, default stuff/idle
//          thresholds and a 3-input majority helper for triple sampling.
// Ports:   none (package).
package can_pkg;

  typedef enum logic [1:0] {
    SEEK_IDLE = 2'd0,
    WAIT_SOF  = 2'd1,
    RX        = 2'd2
  } can_state_e;

  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;

  localparam int CAN_STUFF_RUN_DEF = 5;
  localparam int CAN_IDLE_BITS_DEF = 11;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/can_bit_timing.sv
// rtl/can_bit_timing.sv - rx synchroniser, in-bit counter, hard/re-sync and sample strobe
// Purpose: synchronises rx, detects recessive->dominant edges, runs the in-bit
//          counter with hard sync (outside RX) and SJW-bounded resync (in RX),
//          and produces a sample strobe with the sampled bit value.
// Config:  CAN_TRIPLE_SAMPLE_EN selects majority-of-three sampling decided at
//          sample_pt+1; otherwise a single sample at sample_pt.
// Ports:   clk, rst_n        clock, synchronous active-low reset
//          rx                asynchronous raw CAN rx
//          bit_len_i         clocks per bit
//          sample_pt_i       counter value of the sample point
//          sjw_i             resync window half-width
//          rx_mode_i         1 = receiving a frame (resync rules apply)
//          fall_o            synchronised falling edge seen this cycle
//          sample_o          sample strobe (combinational)
//          sample_bit_o      sampled bit value, valid with sample_o
//          phase_err_o       edge in RX outside the resync window
module can_bit_timing import can_pkg::*; #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic [CNT_W-1:0] bit_len_i,
  input  logic [CNT_W-1:0] sample_pt_i,
  input  logic [CNT_W-1:0] sjw_i,
  input  logic             rx_mode_i,
  output logic             fall_o,
  output logic             sample_o,
  output logic             sample_bit_o,
  output logic             phase_err_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   resynced_q, resynced_d;
  logic                   in_window;
  logic                   resync;

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign fall_o = (rx_prev_q == CAN_RECESSIVE) && (rx_s == CAN_DOMINANT);

  // cnt==0 is the on-time edge position, so it is neither a resync nor an error.
  assign in_window = ((cnt_q >= CNT_ONE) && (cnt_q <= sjw_i)) ||
                     (cnt_q >= (bit_len_i - sjw_i));
  assign resync      = fall_o && rx_mode_i && !resynced_q && in_window;
  assign phase_err_o = fall_o && rx_mode_i && !resynced_q && (cnt_q != '0) && !in_window;

  always_comb begin
    cnt_d      = cnt_q + CNT_ONE;
    resynced_d = resynced_q;
    if ((fall_o && !rx_mode_i) || resync) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q >= (bit_len_i - CNT_ONE)) begin
      cnt_d = '0;
    end
    // A "bit" for the one-resync limit runs sample point to sample point, so a
    // late-window resync does not block the early window of the same bit.
    if (!rx_mode_i || (cnt_q == sample_pt_i)) begin
      resynced_d = 1'b0;
    end
    if (resync) begin
      resynced_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rx_prev_q  <= CAN_RECESSIVE;
      cnt_q      <= '0;
      resynced_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q  <= rx_s;
      cnt_q      <= cnt_d;
      resynced_q <= resynced_d;
    end
  end

`ifdef CAN_TRIPLE_SAMPLE_EN
  logic s_early_q, s_mid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_early_q <= CAN_RECESSIVE;
      s_mid_q   <= CAN_RECESSIVE;
    end else begin
      if (cnt_q == (sample_pt_i - CNT_ONE)) s_early_q <= rx_s;
      if (cnt_q == sample_pt_i)             s_mid_q   <= rx_s;
    end
  end

  assign sample_o     = (cnt_q == (sample_pt_i + CNT_ONE));
  assign sample_bit_o = maj3(s_early_q, s_mid_q, rx_s);
`else
  assign sample_o     = (cnt_q == sample_pt_i);
  assign sample_bit_o = rx_s;
`endif

endmodule

// File: rtl/can_bit_receiver.sv
// rtl/can_bit_receiver.sv - CAN bit-level receive front end
// Purpose: bus idle search, SOF hard sync, destuffing and stuff-error
//          detection on top of can_bit_timing; emits destuffed bits.
// Config:  CAN_TRIPLE_SAMPLE_EN (in can_bit_timing) adds one clock of latency.
// Ports:   clk, rst_n   clock, synchronous active-low reset
//          rx           asynchronous raw CAN rx (1 = recessive)
//          bit_len, sample_pt, sjw   bit timing, latched on WAIT_SOF entry
//          stuff_en     destuffing enable
//          frame_done   frame finished pulse, returns to idle search
//          bit_valid, bit_data       destuffed bit strobe and value
//          sof, stuff_err, phase_err strobes
//          bus_idle, busy            levels
module can_bit_receiver import can_pkg::*; #(
  parameter int CNT_W       = 8,
  parameter int STUFF_RUN   = CAN_STUFF_RUN_DEF,
  parameter int IDLE_BITS   = CAN_IDLE_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic [CNT_W-1:0] bit_len,
  input  logic [CNT_W-1:0] sample_pt,
  input  logic [CNT_W-1:0] sjw,
  input  logic             stuff_en,
  input  logic             frame_done,
  output logic             bit_valid,
  output logic             bit_data,
  output logic             sof,
  output logic             stuff_err,
  output logic             phase_err,
  output logic             bus_idle,
  output logic             busy
);

  localparam int IDLE_W = $clog2(IDLE_BITS + 1);
  localparam int RUN_W  = $clog2(STUFF_RUN + 1);

  can_state_e        state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              run_val_q, run_val_d;
  logic              bus_idle_q, bus_idle_d;
  logic              busy_q, busy_d;
  logic              bit_valid_q, bit_valid_d;
  logic              bit_data_q, bit_data_d;
  logic              stuff_err_q, stuff_err_d;
  logic [CNT_W-1:0]  bit_len_q, sample_pt_q, sjw_q;
  logic [CNT_W-1:0]  bit_len_m, sample_pt_m, sjw_m;
  logic              fall, sample, sample_bit;

  // Timing follows the ports while hunting for idle, then is frozen for the frame.
  assign bit_len_m   = (state_q == SEEK_IDLE) ? bit_len   : bit_len_q;
  assign sample_pt_m = (state_q == SEEK_IDLE) ? sample_pt : sample_pt_q;
  assign sjw_m       = (state_q == SEEK_IDLE) ? sjw       : sjw_q;

  can_bit_timing #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .bit_len_i    (bit_len_m),
    .sample_pt_i  (sample_pt_m),
    .sjw_i        (sjw_m),
    .rx_mode_i    (state_q == RX),
    .fall_o       (fall),
    .sample_o     (sample),
    .sample_bit_o (sample_bit),
    .phase_err_o  (phase_err)
  );

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    run_d       = run_q;
    run_val_d   = run_val_q;
    bus_idle_d  = bus_idle_q;
    busy_d      = busy_q;
    bit_valid_d = 1'b0;
    bit_data_d  = bit_data_q;
    stuff_err_d = 1'b0;
    sof         = 1'b0;
    case (state_q)
      SEEK_IDLE: begin
        if (sample) begin
          if (sample_bit == CAN_RECESSIVE) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            if (idle_cnt_d == IDLE_W'(IDLE_BITS)) begin
              state_d    = WAIT_SOF;
              bus_idle_d = 1'b1;
            end
          end else begin
            idle_cnt_d = '0;
          end
        end
      end
      WAIT_SOF: begin
        if (fall) begin
          sof        = 1'b1;
          state_d    = RX;
          bus_idle_d = 1'b0;
          busy_d     = 1'b1;
          run_d      = '0;  // the SOF sample itself seeds run=1
        end
      end
      RX: begin
        if (!stuff_en) begin
          run_d = '0;
          if (sample) begin
            bit_valid_d = 1'b1;
            bit_data_d  = sample_bit;
          end
        end else if (sample) begin
          if (run_q == RUN_W'(STUFF_RUN)) begin
            if (sample_bit != run_val_q) begin
              run_d     = RUN_W'(1);
              run_val_d = sample_bit;
            end else begin
              stuff_err_d = 1'b1;
              state_d     = SEEK_IDLE;
              busy_d      = 1'b0;
              idle_cnt_d  = '0;
            end
          end else begin
            bit_valid_d = 1'b1;
            bit_data_d  = sample_bit;
            if ((run_q != '0) && (sample_bit == run_val_q)) begin
              run_d = run_q + RUN_W'(1);
            end else begin
              run_d     = RUN_W'(1);
              run_val_d = sample_bit;
            end
          end
        end
        // The strobe computed above still goes out; only the state is overridden.
        if (frame_done) begin
          state_d    = SEEK_IDLE;
          busy_d     = 1'b0;
          idle_cnt_d = '0;
        end
      end
      default: state_d = SEEK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEEK_IDLE;
      idle_cnt_q  <= '0;
      run_q       <= '0;
      run_val_q   <= 1'b0;
      bus_idle_q  <= 1'b0;
      busy_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
      stuff_err_q <= 1'b0;
      bit_len_q   <= '0;
      sample_pt_q <= '0;
      sjw_q       <= '0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      run_q       <= run_d;
      run_val_q   <= run_val_d;
      bus_idle_q  <= bus_idle_d;
      busy_q      <= busy_d;
      bit_valid_q <= bit_valid_d;
      bit_data_q  <= bit_data_d;
      stuff_err_q <= stuff_err_d;
      if (state_q == SEEK_IDLE) begin
        bit_len_q   <= bit_len;
        sample_pt_q <= sample_pt;
        sjw_q       <= sjw;
      end
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_data  = bit_data_q;
  assign stuff_err = stuff_err_q;
  assign bus_idle  = bus_idle_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_can_bit_receiver.sv
// tb/tb_can_bit_receiver.sv - scoreboard bench for can_bit_receiver
module tb_can_bit_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] bit_len, sample_pt, sjw;
  logic       stuff_en, frame_done;
  logic       bit_valid, bit_data, sof, stuff_err, phase_err, bus_idle, busy;

  always #5 clk = ~clk;

  can_bit_receiver #(
    .CNT_W(8), .STUFF_RUN(5), .IDLE_BITS(11), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .bit_len(bit_len), .sample_pt(sample_pt), .sjw(sjw),
    .stuff_en(stuff_en), .frame_done(frame_done),
    .bit_valid(bit_valid), .bit_data(bit_data), .sof(sof),
    .stuff_err(stuff_err), .phase_err(phase_err),
    .bus_idle(bus_idle), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit exp_q[$];
  int bv_cyc_q[$];
  int bv_total = 0, last_bv_cyc = 0;
  int sof_cnt = 0, sof_cyc = 0, pe_cnt = 0, se_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every bit_valid pops one expected bit from the scoreboard.
  always @(negedge clk) begin
    if (bit_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_bit_valid: actual data %0d expected no strobe at cycle %0d", bit_data, cyc);
      end else begin
        check("bit_data", bit_data, exp_q.pop_front());
      end
      bv_total++;
      last_bv_cyc = cyc;
      bv_cyc_q.push_back(cyc);
    end
    if (sof) begin
      sof_cnt++;
      sof_cyc = cyc;
    end
    if (phase_err) pe_cnt++;
    if (stuff_err) se_cnt++;
  end

  function automatic logic [6:0] outs();
    return {bit_valid, bit_data, sof, stuff_err, phase_err, bus_idle, busy};
  endfunction

  task automatic send(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_n(input logic v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  initial begin
    int c0, c_c, c_d, pe0, se0, sof0, bv0;
    rst_n = 1'b0; rx = 1'b1; stuff_en = 1'b1; frame_done = 1'b0;
    bit_len = 8'd96; sample_pt = 8'd60; sjw = 8'd9;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst_n = 1'b1;

    // Bus idle needs 11 recessive samples (11th near 1021 clocks after reset).
    repeat (1000) @(negedge clk);
    check("idle_before_11th", bus_idle, 0);
    repeat (100) @(negedge clk);
    check("idle_after_11th", bus_idle, 1);

    // Frame A: 0,0,0,0,0,1(stuff),1,0 -> 0,0,0,0,0,1,0
    bv_cyc_q.delete();
    sof0 = sof_cnt; pe0 = pe_cnt;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
    c0 = cyc;
    send(0, 5 * 96); send(1, 2 * 96); send(0, 96);
    rx = 1'b1;
    check("sof_count_A", sof_cnt - sof0, 1);
    check("sof_latency", sof_cyc - c0, 2);
    check("bv_count_A", bv_cyc_q.size(), 7);
    if (bv_cyc_q.size() >= 2) begin
      check("first_bv_after_sof", bv_cyc_q[0] - sof_cyc, 61);
      check("bv_period", bv_cyc_q[1] - bv_cyc_q[0], 96);
    end
    check("busy_in_frame", busy, 1);
    check("idle_in_frame", bus_idle, 0);
    check("no_phase_err_A", pe_cnt - pe0, 0);
    pulse_done();
    check("busy_after_done", busy, 0);
    check("queue_empty_A", exp_q.size(), 0);

    // Stuff error: six dominant bits.
    send(1, 12 * 96);
    check("idle_before_B", bus_idle, 1);
    se0 = se_cnt;
    push_n(0, 5);
    send(0, 6 * 96);
    rx = 1'b1;
    check("stuff_err_count", se_cnt - se0, 1);
    check("busy_after_stuff_err", busy, 0);
    check("idle_after_stuff_err", bus_idle, 0);
    check("queue_empty_B", exp_q.size(), 0);

    // Resync at cnt=5, then phase error at cnt=40.
    send(1, 12 * 96);
    pe0 = pe_cnt;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    send(0, 96);
    send(1, 101);
    c_c = cyc;
    send(0, 96);
    check("no_phase_err_cnt5", pe_cnt - pe0, 0);
    check("resync_sample_time", last_bv_cyc - c_c, 63);
    c_d = cyc;
    send(1, 40);
    send(0, 56);
    rx = 1'b1;
    check("phase_err_cnt40", pe_cnt - pe0, 1);
    check("no_resync_sample_time", last_bv_cyc - c_d, 63);
    pulse_done();
    check("queue_empty_C", exp_q.size(), 0);

    // Transmitter at 94 clocks/bit, alternating data, 200 bits.
    send(1, 12 * 96);
    pe0 = pe_cnt; se0 = se_cnt; bv0 = bv_total;
    for (int i = 0; i < 200; i++) exp_q.push_back(i[0]);
    for (int i = 0; i < 200; i++) send(i[0], 94);
    rx = 1'b1;
    pulse_done();
    check("drift_bv_count", bv_total - bv0, 200);
    check("drift_phase_err", pe_cnt - pe0, 0);
    check("drift_stuff_err", se_cnt - se0, 0);
    check("queue_empty_D", exp_q.size(), 0);

    // Reset mid-frame.
    send(1, 12 * 96);
    exp_q.push_back(0);
    send(0, 96);
    send(1, 30);
    rst_n = 1'b0;
    @(negedge clk);
    check("midframe_reset_outputs", outs(), 0);
    rst_n = 1'b1;
    sof0 = sof_cnt;
    send(0, 96);
    send(1, 3 * 96);
    check("no_sof_before_idle", sof_cnt - sof0, 0);
    check("not_busy_before_idle", busy, 0);
    send(1, 9 * 96);
    check("idle_after_reset", bus_idle, 1);
    exp_q.push_back(0);
    send(0, 96);
    rx = 1'b1;
    check("sof_after_idle", sof_cnt - sof0, 1);
    pulse_done();
    repeat (10) @(negedge clk);
    check("queue_empty_E", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
